// File: rtl/mem_arb.sv
// Two-requester (fetch, load/store) arbiter onto one shared memory port with a watchdog.
// Optional round-robin contention policy enabled by defining MEM_ARB_ROUND_ROBIN_EN.
module mem_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_adr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned WD_W = 8;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_XFER = 2'd1,
        LS_XFER = 2'd2
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            grant_ls_c;
    logic            acking_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_ls;
`endif

    // Contention policy: which requester wins when both are pending in IDLE.
    always_comb begin
        grant_ls_c = ls_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ls_req && if_req) begin
            grant_ls_c = !last_ls;
        end
`endif
    end

    // A completion pulse in flight blocks the next grant so a still-held request is not re-served.
    assign acking_c = if_ack | ls_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wd        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls   <= 1'b1;
`endif
        end else begin
            if_ack   <= 1'b0;
            ls_ack   <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if ((if_req || ls_req) && !acking_c) begin
                        wd      <= '0;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        if (grant_ls_c) begin
                            state     <= LS_XFER;
                            owner     <= 1'b1;
                            mem_we    <= ls_we;
                            mem_adr   <= ls_adr;
                            mem_wdata <= ls_wdata;
                            mem_be    <= ls_be;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_ls   <= 1'b1;
`endif
                        end else begin
                            state     <= IF_XFER;
                            owner     <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_adr   <= if_adr;
                            mem_wdata <= '0;
                            mem_be    <= 4'hF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            last_ls   <= 1'b0;
`endif
                        end
                    end
                end
                IF_XFER, LS_XFER: begin
                    // Completion or watchdog expiry; a real ack always beats the timeout.
                    if (mem_ack || (wd == WD_LIMIT)) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        err     <= !mem_ack;
                        if (state == IF_XFER) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : 32'h0;
                        end else begin
                            ls_ack   <= 1'b1;
                            ls_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'h0;
                        end
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: stimulus pushes expected grants/responses, a monitor checks them.
module tb_mem_arb;

    localparam int unsigned T = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack;
    logic [31:0] if_adr, if_rdata;
    logic        ls_req, ls_we, ls_ack;
    logic [31:0] ls_adr, ls_wdata, ls_rdata;
    logic [3:0]  ls_be;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        err, busy, owner;

    mem_arb #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_adr(ls_adr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    typedef struct {
        int          k;
        logic [31:0] data;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    model_last_ls = 1'b1;
    bit    stray_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Memory model: acks in the k-th transfer cycle of each grant (k > T means never).
    initial begin : responder
        int    cyc;
        bit    active;
        plan_t p;
        cyc = 0;
        active = 1'b0;
        p.k = 0;
        p.data = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (rst) begin
                active = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cyc = 1;
                    if (plan_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant actual=1 required=0 at %0t", $time);
                        p.k = 1000;
                    end else begin
                        p = plan_q.pop_front();
                    end
                end else begin
                    cyc++;
                end
                if (cyc == p.k) begin
                    mem_ack = 1'b1;
                    mem_rdata = p.data;
                end
            end else begin
                active = 1'b0;
                mem_ack = stray_en && ($urandom_range(0, 5) == 0);
            end
        end
    end

    // Monitor: checks the held command during transfers and every completion pulse.
    initial begin : monitor
        int   xfer;
        exp_t e;
        xfer = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                xfer = 0;
            end else begin
                if (if_ack || ls_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack actual=%b%b required=00 at %0t", if_ack, ls_ack, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_owner", 32'({if_ack, ls_ack}), e.owner ? 32'd1 : 32'd2);
                        check("owner_rdata", e.owner ? ls_rdata : if_rdata, e.rdata);
                        check("other_rdata", e.owner ? if_rdata : ls_rdata, 32'h0);
                        check("err", 32'(err), 32'(e.err));
                        check("xfer_cycles", 32'(xfer), 32'(e.cycles));
                    end
                    xfer = 0;
                end else begin
                    check("quiet_outputs", 32'(err) | if_rdata | ls_rdata, 32'h0);
                end
                if (mem_req) begin
                    xfer++;
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        check("mem_adr", mem_adr, e.adr);
                        check("mem_wdata", mem_wdata, e.wdata);
                        check("mem_we_be", 32'({mem_we, mem_be}), 32'({e.we, e.be}));
                        check("busy_owner", 32'({busy, owner}), 32'({1'b1, e.owner}));
                    end
                end else begin
                    check("busy_low", 32'(busy), 32'h0);
                end
            end
        end
    end

    task automatic round(input bit do_if, input bit do_ls, input bit early,
                         input logic [31:0] ia, input bit we, input logic [31:0] la,
                         input logic [31:0] wd, input logic [3:0] be,
                         input int k_if, input logic [31:0] d_if,
                         input int k_ls, input logic [31:0] d_ls);
        exp_t  ei, el;
        plan_t pi, pl;
        bit    ls_first, if_done, ls_done;
        int    budget;
        ei.owner = 1'b0; ei.we = 1'b0; ei.adr = ia; ei.wdata = '0; ei.be = 4'hF;
        ei.err = (k_if > int'(T));
        ei.rdata = ei.err ? 32'h0 : d_if;
        ei.cycles = ei.err ? int'(T) : k_if;
        el.owner = 1'b1; el.we = we; el.adr = la; el.wdata = wd; el.be = be;
        el.err = (k_ls > int'(T));
        el.rdata = (el.err || we) ? 32'h0 : d_ls;
        el.cycles = el.err ? int'(T) : k_ls;
        pi.k = k_if; pi.data = d_if;
        pl.k = k_ls; pl.data = d_ls;
        if (do_if && do_ls) ls_first = RR ? !model_last_ls : 1'b1;
        else ls_first = do_ls;
        if (do_ls && ls_first) begin exp_q.push_back(el); plan_q.push_back(pl); end
        if (do_if) begin exp_q.push_back(ei); plan_q.push_back(pi); end
        if (do_ls && !ls_first) begin exp_q.push_back(el); plan_q.push_back(pl); end
        model_last_ls = (do_if && do_ls) ? !ls_first : do_ls;

        @(posedge clk);
        #1;
        if_req = do_if; if_adr = ia;
        ls_req = do_ls; ls_we = we; ls_adr = la; ls_wdata = wd; ls_be = be;
        if_done = !do_if;
        ls_done = !do_ls;
        budget = 0;
        while (!(if_done && ls_done) && budget < 60) begin
            @(negedge clk);
            if (if_ack) if_done = 1'b1;
            if (ls_ack) ls_done = 1'b1;
            @(posedge clk);
            #1;
            // A requester that has dropped its request scrambles its bus to expose unlatched commands.
            if (if_done || early) begin if_req = 1'b0; if_adr = $urandom; end
            if (ls_done || early) begin
                ls_req = 1'b0; ls_adr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom);
            end
            budget++;
        end
        checks++;
        if (!(if_done && ls_done)) begin
            errors++;
            $display("FAIL round_done actual=%b%b required=11", if_done, ls_done);
            if_req = 1'b0;
            ls_req = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin : stimulus
        bit pat_if, pat_ls;
        rst = 1'b1;
        if_req = 1'b0; if_adr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_adr = '0; ls_wdata = '0; ls_be = '0;
        #12;
        check("reset_mem_req_busy", 32'({mem_req, busy, owner, err}), 32'h0);
        check("reset_mem_cmd", mem_adr | mem_wdata | 32'({mem_we, mem_be}), 32'h0);
        check("reset_acks", 32'({if_ack, ls_ack}) | if_rdata | ls_rdata, 32'h0);
        @(posedge clk);
        #3 rst = 1'b0;
        model_last_ls = 1'b1;

        // Fetch read with late ack, then a store acked in its first cycle.
        round(1, 0, 0, 32'h100, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1, 0);
        round(0, 1, 0, 0, 1, 32'h2000, 32'h12345678, 4'h3, 1, 0, 1, 32'hCAFEF00D);
        // Contention held across both transactions.
        round(1, 1, 0, 32'h300, 0, 32'h400, 32'h0, 4'hF, 2, 32'h11112222, 1, 32'h33334444);
        // Watchdog expiry, and ack coinciding with the final watchdog cycle.
        round(1, 0, 0, 32'h500, 0, 0, 0, 0, T + 3, 32'h55555555, 1, 0);
        round(0, 1, 0, 0, 0, 32'h600, 32'h0, 4'h1, 1, 0, T, 32'h66666666);

        // Reset in the middle of a load transfer.
        @(posedge clk);
        #1;
        exp_q.delete();
        plan_q.push_back('{k: 1000, data: 32'h0});
        ls_req = 1'b1; ls_we = 1'b0; ls_adr = 32'h700; ls_wdata = '0; ls_be = 4'hF;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_mem_req", 32'(mem_req), 32'h1);
        rst = 1'b1;
        #1;
        check("async_reset_mem_req", 32'({mem_req, busy}), 32'h0);
        check("async_reset_ls_ack", 32'(ls_ack), 32'h0);
        plan_q.delete();
        ls_req = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        model_last_ls = 1'b1;
        repeat (3) @(posedge clk);
        round(1, 0, 0, 32'h800, 0, 0, 0, 0, 2, 32'h88888888, 1, 0);

        // Randomized traffic with stray memory acks while idle.
        stray_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0: begin pat_if = 1'b1; pat_ls = 1'b0; end
                1: begin pat_if = 1'b0; pat_ls = 1'b1; end
                default: begin pat_if = 1'b1; pat_ls = 1'b1; end
            endcase
            round(pat_if, pat_ls, !(pat_if && pat_ls) && ($urandom_range(0, 3) == 0),
                  $urandom, 1'($urandom), $urandom, $urandom, 4'($urandom),
                  $urandom_range(1, T + 2), $urandom,
                  $urandom_range(1, T + 2), $urandom);
        end
        stray_en = 1'b0;
        repeat (4) @(posedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        check("plan_queue_drained", 32'(plan_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, number of cycles a granted access waits for MEM_ACK before abort; legal range 2..255.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset; asynchronous, active-high.
REQ-004 IF_REQ  in  1  instruction-fetch read request; held until IF_ACK.
REQ-005 IF_ADR  in  32  fetch address.
REQ-006 IF_ACK  out  1  one-cycle completion pulse to fetch.
REQ-007 IF_RDATA  out  32  fetch read data; valid with IF_ACK.
REQ-008 LS_REQ  in  1  load/store request; held until LS_ACK.
REQ-009 LS_WE  in  1  1 = store, 0 = load.
REQ-010 LS_ADR  in  32  load/store address.
REQ-011 LS_WDATA  in  32  store data.
REQ-012 LS_BE  in  4  byte enables.
REQ-013 LS_ACK  out  1  one-cycle completion pulse to load/store.
REQ-014 LS_RDATA  out  32  load data; valid with LS_ACK.
REQ-015 MEM_REQ  out  1  shared memory port request.
REQ-016 MEM_WE, MEM_ADR, MEM_WDATA, MEM_BE  out  1/32/32/4  shared port command.
REQ-017 MEM_ACK  in  1  memory completion; MEM_RDATA valid in the same cycle.
REQ-018 MEM_RDATA  in  32  memory read data.
REQ-019 ERR  out  1  pulses with IF_ACK/LS_ACK when the access timed out.
REQ-020 BUSY  out  1  high while a transaction is owned; OWNER  out  1  0 = fetch, 1 = load/store, valid while BUSY.

Function
REQ-021 FSM states IDLE, IF_XFER, LS_XFER; BUSY = (state != IDLE); all outputs registered.
REQ-022 IDLE: a request sampled at edge N moves the FSM to the owning XFER state; MEM_REQ and the latched command are driven from edge N (visible cycle N+1).
REQ-023 IF grant: MEM_WE=0, MEM_BE=4'hF, MEM_ADR=IF_ADR, MEM_WDATA=0; LS grant copies LS_WE/LS_ADR/LS_WDATA/LS_BE.
REQ-024 MEM_* command stays constant and MEM_REQ stays high until MEM_ACK is sampled high.
REQ-025 On MEM_ACK: MEM_REQ drops, owner ACK pulses for exactly one cycle with RDATA = captured MEM_RDATA (0 for stores), ERR=0, FSM returns to IDLE.
REQ-026 Minimum transaction spacing: next grant no earlier than the edge after return to IDLE; requests pending during the ACK cycle wait.
REQ-027 Watchdog 8-bit counter clears on grant, increments each XFER cycle without MEM_ACK; reaching TIMEOUT_CYCLES-1 drops MEM_REQ, pulses owner ACK with ERR=1, RDATA=0, returns to IDLE.
REQ-028 MEM_ACK and timeout in the same cycle: MEM_ACK wins, ERR=0.
REQ-029 MEM_ACK while IDLE is ignored; no ACK or ERR produced.
REQ-030 Requester deasserting REQ mid-transaction does not abort; the ACK is still issued.
REQ-031 Non-owner ACK, RDATA stay 0; IF_RDATA/LS_RDATA hold 0 outside ACK cycles.

Reset
REQ-032 RST high forces immediately: state IDLE, MEM_REQ=0, MEM_WE=0, MEM_ADR=0, MEM_WDATA=0, MEM_BE=0, IF_ACK=LS_ACK=0, IF_RDATA=LS_RDATA=0, ERR=0, BUSY=0, OWNER=0, watchdog=0, last-served=LS.
REQ-033 Reset mid-transaction abandons it silently; no ACK issued after release; first grant no earlier than the first edge after RST falls.

Configuration
REQ-034 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous IF_REQ and LS_REQ in IDLE, grant the requester not last served; last-served flop updates on every grant.
REQ-035 Macro undefined: fixed priority, LS over IF on contention; last-served flop absent.

Verification
REQ-036 Single IF_REQ ADR=0x100, MEM_ACK after 3 cycles with RDATA=0xDEADBEEF -> IF_ACK one cycle, IF_RDATA=0xDEADBEEF, ERR=0, MEM_WE=0, MEM_BE=0xF.
REQ-037 LS store ADR=0x2000 WDATA=0x12345678 BE=0x3, MEM_ACK next cycle -> MEM_WE=1, MEM_BE=0x3, LS_ACK pulse, LS_RDATA=0.
REQ-038 IF_REQ and LS_REQ together, held for two transactions -> fixed build: LS then IF; MEM_ARB_ROUND_ROBIN_EN build: IF then LS.
REQ-039 IF_REQ, MEM_ACK never asserted, TIMEOUT_CYCLES=4 -> MEM_REQ drops after 4 XFER cycles, IF_ACK=1 and ERR=1 same cycle, IF_RDATA=0.
REQ-040 RST pulsed while LS_XFER with MEM_REQ=1 -> MEM_REQ=0 without clock edge, no LS_ACK, subsequent IF_REQ served normally.
